// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one handshake memory port between CPU (port 0) and loader (port 1)
module mem_port_arbiter #(
  parameter int DATA_W  = 48,
  parameter int ADDR_W  = 48,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic [DATA_W-1:0] RDATA0,
  output logic              ACK0,
  output logic              WAIT0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [DATA_W-1:0] RDATA1,
  output logic              ACK1,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WD,
  input  logic [DATA_W-1:0] MEM_RD,
  input  logic              MEM_HS,
  output logic [1:0]        GRANT,
  output logic              TIMEOUT_ERR
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HS, RESP} state_t;
  state_t state;
  logic ptr, owner, pick, timedOut;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] respData;
  assign pick = (REQ0 & REQ1) ? ptr : REQ1;
  assign timedOut = cnt == CW'(TIMEOUT - 1);
  // a timed-out read returns zero so the CPU never latches stale bus data
  assign respData = MEM_HS ? MEM_RD : '0;
  assign WAIT0 = REQ0 & ~ACK0;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      RDATA0      <= '0;
      RDATA1      <= '0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      MEM_EN      <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WD      <= '0;
      GRANT       <= 2'b00;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      MEM_EN <= 1'b0;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      case (state)
        IDLE: if (REQ0 | REQ1) begin
          owner    <= pick;
          GRANT    <= pick ? 2'b10 : 2'b01;
          MEM_WE   <= pick ? WE1 : WE0;
          MEM_ADDR <= pick ? ADDR1 : ADDR0;
          MEM_WD   <= pick ? WDATA1 : WDATA0;
          MEM_EN   <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_HS;
        end
        WAIT_HS: if (MEM_HS | timedOut) begin
          if (!MEM_WE && owner) RDATA1 <= respData;
          if (!MEM_WE && !owner) RDATA0 <= respData;
          if (!MEM_HS) TIMEOUT_ERR <= 1'b1;
          ACK0  <= ~owner;
          ACK1  <= owner;
          state <= RESP;
        end else begin
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
        end
        RESP: begin
          ptr   <= ~owner;
          GRANT <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a transaction-level model of the arbiter
module tb_mem_port_arbiter;
  localparam int DW = 48, AW = 48, TO = 16;
  logic CLK = 0, RESET = 1;
  logic REQ0 = 0, WE0 = 0, REQ1 = 0, WE1 = 0, MEM_HS = 0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0, MEM_RD = '0;
  logic [DW-1:0] RDATA0, RDATA1, MEM_WD;
  logic [AW-1:0] MEM_ADDR;
  logic ACK0, ACK1, WAIT0, MEM_EN, MEM_WE, TIMEOUT_ERR;
  logic [1:0] GRANT;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .RDATA0(RDATA0), .ACK0(ACK0), .WAIT0(WAIT0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .RDATA1(RDATA1), .ACK1(ACK1),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD), .MEM_HS(MEM_HS),
    .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {bit port; bit we; logic [AW-1:0] addr; logic [DW-1:0] wd;} issue_t;
  typedef struct {bit port; logic [DW-1:0] rd0; logic [DW-1:0] rd1; bit err; int lat;} ack_t;
  typedef struct {int k; logic [DW-1:0] rd;} plan_t;
  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wd; logic [DW-1:0] rd; int k;} txn_t;

  issue_t expIssue[$];
  ack_t expAck[$];
  plan_t plans[$];
  int checks = 0, errors = 0;
  bit mPtr = 0, mErr = 0;
  logic [DW-1:0] mRd0 = '0, mRd1 = '0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [47:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  function automatic txn_t mk(bit we, logic [47:0] a, logic [47:0] wd, logic [47:0] rd, int k);
    txn_t t;
    t.we = we; t.addr = a; t.wd = wd; t.rd = rd; t.k = k;
    return t;
  endfunction

  function automatic txn_t rndTxn(int kMax);
    return mk(1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), $urandom_range(1, kMax));
  endfunction

  // handshake on WAIT_HS cycle k; k beyond TO means the memory never answers
  function automatic int latOf(int k);
    return (k > TO ? TO : k) + 1;
  endfunction

  function automatic void expectTxn(bit p, txn_t t);
    ack_t a;
    expIssue.push_back('{p, t.we, t.addr, t.wd});
    plans.push_back('{t.k, t.rd});
    if (t.k > TO) mErr = 1;
    if (!t.we && p) mRd1 = (t.k <= TO) ? t.rd : '0;
    if (!t.we && !p) mRd0 = (t.k <= TO) ? t.rd : '0;
    a.port = p; a.rd0 = mRd0; a.rd1 = mRd1; a.err = mErr; a.lat = latOf(t.k);
    expAck.push_back(a);
  endfunction

  task automatic finishSim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic runRound(input bit [1:0] mask, input txn_t t0, input txn_t t1);
    bit first;
    int n, reqCyc;
    first = (mask == 2'b11) ? mPtr : mask[1];
    expectTxn(first, first ? t1 : t0);
    if (mask == 2'b11) expectTxn(!first, first ? t0 : t1);
    mPtr = (mask == 2'b11) ? first : !first;
    @(negedge CLK);
    MEM_RD = rnd(); MEM_HS = 1;
    @(negedge CLK);
    MEM_HS = 0;
    WE0 = t0.we; ADDR0 = t0.addr; WDATA0 = t0.wd; REQ0 = mask[0];
    WE1 = t1.we; ADDR1 = t1.addr; WDATA1 = t1.wd; REQ1 = mask[1];
    reqCyc = cyc;
    n = 0;
    while ((REQ0 || REQ1) && n < 200) begin
      @(negedge CLK);
      n++;
      if ((ACK0 || ACK1) && mask != 2'b11) chk("ack_after_req", cyc - reqCyc, 1 + latOf(mask[0] ? t0.k : t1.k));
      if (ACK0) begin REQ0 = 0; WE0 = 1'($urandom_range(0, 1)); ADDR0 = rnd(); WDATA0 = rnd(); end
      if (ACK1) begin REQ1 = 0; WE1 = 1'($urandom_range(0, 1)); ADDR1 = rnd(); WDATA1 = rnd(); end
    end
    if (REQ0 || REQ1) begin
      checks++; errors++;
      $display("FAIL round_timeout: got REQ pending=%b%b required both acknowledged", REQ1, REQ0);
      finishSim();
    end
  endtask

  // memory-side responder
  initial forever begin
    plan_t p;
    @(negedge CLK);
    if (RESET && MEM_EN && plans.size() > 0) begin
      p = plans.pop_front();
      if (p.k <= TO) begin
        repeat (p.k) @(negedge CLK);
        MEM_RD = p.rd; MEM_HS = 1;
        @(negedge CLK);
        MEM_HS = 0; MEM_RD = rnd();
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT issues or acknowledges
  initial begin
    issue_t cur;
    ack_t a;
    bit active = 0, prevAck = 0;
    int enCyc = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        active = 0; prevAck = 0;
      end else begin
        chk("wait0", WAIT0, REQ0 & ~ACK0);
        if (active && !MEM_EN) begin
          chk("hold_addr", MEM_ADDR, cur.addr);
          chk("hold_wd", MEM_WD, cur.wd);
          chk("hold_we", MEM_WE, cur.we);
          chk("hold_grant", GRANT, cur.port ? 2'b10 : 2'b01);
        end
        if (prevAck) chk("grant_idle", GRANT, 2'b00);
        if (MEM_EN) begin
          if (expIssue.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_en: got MEM_EN=1 required no transaction");
          end else begin
            cur = expIssue.pop_front();
            chk("issue_grant", GRANT, cur.port ? 2'b10 : 2'b01);
            chk("issue_we", MEM_WE, cur.we);
            chk("issue_addr", MEM_ADDR, cur.addr);
            chk("issue_wd", MEM_WD, cur.wd);
            enCyc = cyc; active = 1;
          end
        end
        if (ACK0 || ACK1) begin
          if (expAck.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ACK=%b%b required none", ACK1, ACK0);
          end else begin
            a = expAck.pop_front();
            chk("ack_port", {ACK1, ACK0}, a.port ? 2'b10 : 2'b01);
            chk("rdata0", RDATA0, a.rd0);
            chk("rdata1", RDATA1, a.rd1);
            chk("timeout_err", TIMEOUT_ERR, a.err);
            chk("ack_latency", cyc - enCyc, a.lat);
          end
          active = 0;
        end
        prevAck = ACK0 || ACK1;
      end
    end
  end

  task automatic checkAllZero(string tag);
    chk({tag, "_rdata0"}, RDATA0, 0);
    chk({tag, "_rdata1"}, RDATA1, 0);
    chk({tag, "_acks"}, {ACK1, ACK0}, 0);
    chk({tag, "_mem_ctl"}, {MEM_EN, MEM_WE}, 0);
    chk({tag, "_mem_addr"}, MEM_ADDR, 0);
    chk({tag, "_mem_wd"}, MEM_WD, 0);
    chk({tag, "_grant"}, GRANT, 0);
    chk({tag, "_timeout_err"}, TIMEOUT_ERR, 0);
  endtask

  initial begin
    int n;
    txn_t idle0;
    idle0 = mk(0, '0, '0, '0, 1);
    #1 RESET = 0;
    #2 checkAllZero("reset");
    repeat (3) @(negedge CLK);
    #2 RESET = 1;
    runRound(2'b01, mk(0, 48'h10, 48'h0, 48'h0000_0000_BEEF, 1), idle0);
    runRound(2'b10, idle0, mk(1, 48'h20, 48'h1234_5678_9ABC, 48'hDEAD_0000_0001, 6));
    runRound(2'b01, mk(0, 48'h30, 48'h0, 48'hA5A5_5A5A_0F0F, 16), idle0);
    for (int i = 0; i < 15; i++)
      runRound(2'($urandom_range(1, 3)), rndTxn(16), rndTxn(16));
    runRound(2'b01, mk(0, 48'h40, 48'h0, 48'h1111_2222_3333, 40), idle0);
    runRound(2'b01, mk(0, 48'h50, 48'h0, 48'h4444_5555_6666, 2), idle0);
    for (int i = 0; i < 25; i++)
      runRound(2'($urandom_range(1, 3)), rndTxn(20), rndTxn(20));
    // abandon a port-1 read mid-handshake with an asynchronous reset
    @(negedge CLK);
    expIssue.push_back('{1'b1, 1'b0, 48'hCAFE_0000_0777, 48'h0});
    plans.push_back('{99, 48'h0});
    WE1 = 0; ADDR1 = 48'hCAFE_0000_0777; WDATA1 = 48'h0; REQ1 = 1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!MEM_EN && n < 20);
    chk("reset_test_issue", MEM_EN, 1);
    repeat (3) @(negedge CLK);
    #2 RESET = 0;
    #1 checkAllZero("midreset");
    REQ1 = 0;
    mPtr = 0; mErr = 0; mRd0 = '0; mRd1 = '0;
    repeat (2) @(negedge CLK);
    #2 RESET = 1;
    runRound(2'b11, mk(0, 48'h60, 48'h0, 48'h0000_7777_8888, 1), mk(0, 48'h70, 48'h0, 48'h0000_9999_AAAA, 3));
    runRound(2'b11, mk(1, 48'h80, 48'hFEED_FACE_0001, 48'h0, 2), mk(0, 48'h90, 48'h0, 48'h0BAD_C0DE_0002, 1));
    runRound(2'b01, rndTxn(16), idle0);
    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", expIssue.size() + expAck.size(), 0);
    finishSim();
  end
endmodule
